// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - opcodes, FSM states and defaults shared by the interrupt sequencer
package interrupt_sequencer_pkg;

  localparam logic [4:0] OP_RET = 5'b10000;
  localparam logic [4:0] OP_JMP = 5'b11000;
  localparam logic [4:0] OP_JC  = 5'b11001;
  localparam logic [4:0] OP_JZ  = 5'b11010;
  localparam logic [4:0] OP_JNC = 5'b11011;
  localparam logic [4:0] OP_JNZ = 5'b11100;

  localparam logic [7:0] VEC_BASE_DEF = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

endpackage

// File: rtl/interrupt_sequencer_arbiter.sv
// rtl/interrupt_sequencer_arbiter.sv - combinational rotating-start priority pick over eligible sources
module int_priority_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] start_ptr_i,
  output logic [W-1:0] grant_id_o,
  output logic         grant_vld_o
);

  int idx;

  // First eligible source found walking upward from start_ptr_i, wrapping at N.
  always_comb begin
    grant_id_o  = '0;
    grant_vld_o = 1'b0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(start_ptr_i) + i) % N;
      if (!grant_vld_o && elig_i[idx]) begin
        grant_vld_o = 1'b1;
        grant_id_o  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - edge-latched, masked, non-nesting interrupt entry sequencer
// INT_ROUND_ROBIN_EN selects rotating priority; default build is fixed lowest-index priority.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int         N_SRC      = 4,
  parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int         VEC_STRIDE = 4,
  localparam int        IDW        = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_data,
  input  logic [23:0]      ins,
  output logic             interrupt,
  output logic [7:0]       vec_loc,
  output logic             int_active,
  output logic [IDW-1:0]   int_id,
  output logic [N_SRC-1:0] pending
);

  int_state_t       state_q, state_d;
  logic [N_SRC-1:0] irq_q, pending_q, pending_d, mask_q, rise, elig, clr;
  logic [IDW-1:0]   grant_id, start_ptr, int_id_q;
  logic             grant_vld, take, interrupt_q, int_active_q;
  logic [7:0]       vec_q, vec_d;
  logic             unused_ins;

  assign unused_ins = ^ins[18:0];
  assign rise       = irq & ~irq_q;
  assign elig       = pending_q & mask_q;
  assign vec_d      = VEC_BASE + 8'(grant_id) * 8'(VEC_STRIDE);

`ifdef INT_ROUND_ROBIN_EN
  logic [IDW-1:0] rr_q;
  assign start_ptr = rr_q;
`else
  assign start_ptr = '0;
`endif

  int_priority_arbiter #(.N(N_SRC), .W(IDW)) u_arb (
    .elig_i      (elig),
    .start_ptr_i (start_ptr),
    .grant_id_o  (grant_id),
    .grant_vld_o (grant_vld)
  );

  // A jump/RET in decode (ins[23]) holds off entry so a transfer in flight is never pre-empted.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld && !ins[23]) begin
          state_d       = ENTER;
          take          = 1'b1;
          clr[grant_id] = 1'b1;
        end
      end
      ENTER:   state_d = SERVICE;
      SERVICE: if (ins[23:19] == OP_RET) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q & ~clr) | rise;
  end

  // irq_q follows irq through reset so a level already high at release is not an edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      irq_q        <= irq;
      pending_q    <= '0;
      mask_q       <= '0;
      interrupt_q  <= 1'b0;
      int_active_q <= 1'b0;
      int_id_q     <= '0;
      vec_q        <= VEC_BASE;
`ifdef INT_ROUND_ROBIN_EN
      rr_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      irq_q        <= irq;
      pending_q    <= pending_d;
      interrupt_q  <= take;
      int_active_q <= (state_d == SERVICE);
      if (mask_wr) mask_q <= mask_data;
      if (take) begin
        int_id_q <= grant_id;
        vec_q    <= vec_d;
`ifdef INT_ROUND_ROBIN_EN
        rr_q     <= (int'(grant_id) == N_SRC - 1) ? '0 : grant_id + 1'b1;
`endif
      end
    end
  end

  assign interrupt  = interrupt_q;
  assign int_active = int_active_q;
  assign int_id     = int_id_q;
  assign vec_loc    = vec_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - vector table, corner sequences and randomized run against a reference model
module tb_interrupt_sequencer;

  localparam logic [23:0] NOP = 24'h000000;
  localparam logic [23:0] RET = 24'h800000;
  localparam logic [23:0] JMP = 24'hC00000;

  logic        clk = 1'b0;
  logic        reset, mask_wr;
  logic [3:0]  irq, mask_data;
  logic [23:0] ins;
  logic        interrupt, int_active;
  logic [7:0]  vec_loc;
  logic [1:0]  int_id;
  logic [3:0]  pending;

  int n_cmp = 0;
  int n_fail = 0;

  interrupt_sequencer dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_wr(mask_wr), .mask_data(mask_data),
    .ins(ins), .interrupt(interrupt), .vec_loc(vec_loc), .int_active(int_active),
    .int_id(int_id), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference: per-source request flags plus a handler phase (0 free, 1 entering, 2 in handler).
  bit         m_prev[4];
  bit         m_pend[4];
  bit         m_mask[4];
  int         m_phase, m_id, m_rr;
  bit         m_int;
  logic [7:0] m_vec;

  task automatic model_step();
    int win;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_prev[i] = irq[i]; m_pend[i] = 0; m_mask[i] = 0;
      end
      m_phase = 0; m_id = 0; m_rr = 0; m_int = 0; m_vec = 8'hF0;
      return;
    end
    win = -1;
    if (m_phase == 0 && !ins[23])
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_rr + k) % 4;
        if (win < 0 && m_pend[j] && m_mask[j]) win = j;
      end
    m_int = (win >= 0);
    case (m_phase)
      0: m_phase = (win >= 0) ? 1 : 0;
      1: m_phase = 2;
      default: if (ins[23:19] == 5'b10000) m_phase = 0;
    endcase
    if (win >= 0) begin
      m_pend[win] = 0;
      m_id = win;
      m_vec = 8'((240 + win * 4) % 256);
`ifdef INT_ROUND_ROBIN_EN
      m_rr = (win + 1) % 4;
`endif
    end
    for (int i = 0; i < 4; i++) begin
      if (irq[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = irq[i];
    end
    if (mask_wr) for (int i = 0; i < 4; i++) m_mask[i] = mask_data[i];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model();
    logic [3:0] mp;
    for (int i = 0; i < 4; i++) mp[i] = m_pend[i];
    chk("interrupt", 32'(interrupt), 32'(m_int));
    chk("int_active", 32'(int_active), 32'(m_phase == 2));
    chk("int_id", 32'(int_id), 32'(m_id));
    chk("vec_loc", 32'(vec_loc), 32'(m_vec));
    chk("pending", 32'(pending), 32'(mp));
  endtask

  task automatic cyc();
    tick();
    chk_model();
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        mw;
    logic [3:0]  md;
    logic [23:0] ins;
    logic        e_int;
    logic        e_act;
    logic [1:0]  e_id;
    logic [7:0]  e_vec;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t tbl[19];

  initial begin
    reset = 1'b0; irq = '0; mask_wr = 1'b0; mask_data = '0; ins = NOP;

    tbl[0]  = '{1'b0, 4'b0011, 1'b0, 4'h0, NOP, 1'b0, 1'b0, 2'd0, 8'hF0, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0011, 1'b0, 4'h0, NOP, 1'b0, 1'b0, 2'd0, 8'hF0, 4'b0000};
    tbl[2]  = '{1'b1, 4'b0011, 1'b0, 4'h0, NOP, 1'b0, 1'b0, 2'd0, 8'hF0, 4'b0000};
    tbl[3]  = '{1'b1, 4'b0011, 1'b1, 4'hF, NOP, 1'b0, 1'b0, 2'd0, 8'hF0, 4'b0000};
    tbl[4]  = '{1'b1, 4'b0111, 1'b0, 4'h0, NOP, 1'b0, 1'b0, 2'd0, 8'hF0, 4'b0100};
    tbl[5]  = '{1'b1, 4'b0111, 1'b0, 4'h0, NOP, 1'b1, 1'b0, 2'd2, 8'hF8, 4'b0000};
    tbl[6]  = '{1'b1, 4'b0111, 1'b0, 4'h0, NOP, 1'b0, 1'b1, 2'd2, 8'hF8, 4'b0000};
    tbl[7]  = '{1'b1, 4'b0111, 1'b0, 4'h0, NOP, 1'b0, 1'b1, 2'd2, 8'hF8, 4'b0000};
    tbl[8]  = '{1'b1, 4'b0111, 1'b0, 4'h0, RET, 1'b0, 1'b0, 2'd2, 8'hF8, 4'b0000};
    tbl[9]  = '{1'b1, 4'b0111, 1'b0, 4'h0, NOP, 1'b0, 1'b0, 2'd2, 8'hF8, 4'b0000};
    tbl[10] = '{1'b1, 4'b0111, 1'b1, 4'h0, NOP, 1'b0, 1'b0, 2'd2, 8'hF8, 4'b0000};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 4'h0, NOP, 1'b0, 1'b0, 2'd2, 8'hF8, 4'b0000};
    tbl[12] = '{1'b1, 4'b0001, 1'b0, 4'h0, NOP, 1'b0, 1'b0, 2'd2, 8'hF8, 4'b0001};
    tbl[13] = '{1'b1, 4'b0001, 1'b0, 4'h0, NOP, 1'b0, 1'b0, 2'd2, 8'hF8, 4'b0001};
    tbl[14] = '{1'b1, 4'b0001, 1'b1, 4'h1, NOP, 1'b0, 1'b0, 2'd2, 8'hF8, 4'b0001};
    tbl[15] = '{1'b1, 4'b0001, 1'b0, 4'h0, NOP, 1'b1, 1'b0, 2'd0, 8'hF0, 4'b0000};
    tbl[16] = '{1'b1, 4'b0001, 1'b0, 4'h0, NOP, 1'b0, 1'b1, 2'd0, 8'hF0, 4'b0000};
    tbl[17] = '{1'b1, 4'b0001, 1'b0, 4'h0, RET, 1'b0, 1'b0, 2'd0, 8'hF0, 4'b0000};
    tbl[18] = '{1'b1, 4'b0001, 1'b0, 4'h0, NOP, 1'b0, 1'b0, 2'd0, 8'hF0, 4'b0000};

    #2;
    for (int v = 0; v < 19; v++) begin
      reset = tbl[v].rst; irq = tbl[v].irq; mask_wr = tbl[v].mw;
      mask_data = tbl[v].md; ins = tbl[v].ins;
      tick();
      chk($sformatf("tbl%0d_interrupt", v), 32'(interrupt), 32'(tbl[v].e_int));
      chk($sformatf("tbl%0d_int_active", v), 32'(int_active), 32'(tbl[v].e_act));
      chk($sformatf("tbl%0d_int_id", v), 32'(int_id), 32'(tbl[v].e_id));
      chk($sformatf("tbl%0d_vec_loc", v), 32'(vec_loc), 32'(tbl[v].e_vec));
      chk($sformatf("tbl%0d_pending", v), 32'(pending), 32'(tbl[v].e_pend));
    end
    mask_wr = 1'b0; ins = NOP;

    // Simultaneous rises on 1 and 3: id1 first, id3 after RET.
    irq = 4'b0000; mask_wr = 1'b1; mask_data = 4'hF; cyc();
    mask_wr = 1'b0; irq = 4'b1010; cyc();
    cyc();
    chk("dual_first_pulse", 32'(interrupt), 32'd1);
    chk("dual_first_id", 32'(int_id), 32'd1);
    chk("dual_first_vec", 32'(vec_loc), 32'hF4);
    cyc(); ins = RET; cyc(); ins = NOP; cyc();
    chk("dual_second_pulse", 32'(interrupt), 32'd1);
    chk("dual_second_id", 32'(int_id), 32'd3);
    chk("dual_second_vec", 32'(vec_loc), 32'hFC);
    cyc(); ins = RET; cyc(); ins = NOP; cyc();

    // Jump in decode holds off entry until ins[23] drops.
    irq = 4'b0000; cyc();
    irq = 4'b0001; ins = JMP; cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("jmp_block", 32'(interrupt), 32'd0);
    end
    ins = NOP; cyc();
    chk("jmp_release_pulse", 32'(interrupt), 32'd1);
    chk("jmp_release_vec", 32'(vec_loc), 32'hF0);
    cyc(); ins = RET; cyc(); ins = NOP; cyc();

    // Reset in the middle of a handler with source 3 pending.
    irq = 4'b0011; cyc(); cyc(); cyc();
    irq = 4'b1011; cyc();
    chk("svc_pending", 32'(pending), 32'b1000);
    chk("svc_active", 32'(int_active), 32'd1);
    reset = 1'b0; cyc();
    chk("rst_active", 32'(int_active), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rst_no_pulse", 32'(interrupt), 32'd0);
    end

    // Randomized traffic against the model.
    mask_wr = 1'b1; mask_data = 4'hF; cyc();
    for (int n = 0; n < 3000; n++) begin
      int r;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) irq[i] = ~irq[i];
      mask_wr = ($urandom_range(0, 9) == 0);
      mask_data = 4'($urandom);
      r = $urandom_range(0, 7);
      if (r < 4) ins = {1'b0, 23'($urandom)};
      else if (r == 4) ins = JMP;
      else if (r < 7) ins = RET | 24'($urandom_range(0, 255));
      else ins = 24'($urandom);
      reset = ($urandom_range(0, 149) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
